dmem_ctrl: RTL and testbench

Data-memory controller directly downstream of the core's memory stage. It accepts the core's data-memory request (`request`, `we_re`, `mask`, address, store data) and services it against an internal byte-lane-masked word RAM with a configurable number of wait states. It returns the core's `DM_valid` / `DM_load_data_in` handshake, so the pipeline sees realistic multi-cycle memory latency.

---
 rtl/dmem_ctrl_pkg.sv | 26 ++
 rtl/dmem_ctrl_bank.sv | 32 +++
 rtl/dmem_ctrl.sv | 124 ++++++++++++
 tb/tb_dmem_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory controller and its RAM bank.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int LANE_W     = 8;

    // ceil(log2(depth)); exact for the power-of-two depths the RAM uses.
    function automatic int word_index_w(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_ctrl_bank.sv
// Synchronous single-port word RAM with per-byte write enables.
// A write cycle does not refresh rdata, so the last read word stays on the port.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = word_index_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [WORD_BYTES-1:0]        we,
    input  logic [AW-1:0]                addr,
    input  logic [WORD_BYTES*LANE_W-1:0] wdata,
    output logic [WORD_BYTES*LANE_W-1:0] rdata
);

    logic [WORD_BYTES*LANE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we == '0) begin
                rdata <= r_mem[addr];
            end
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (we[i]) begin
                    r_mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: latches a core request, waits WAIT_STATES cycles,
// performs a byte-masked access on the internal bank and pulses valid.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_re,
    input  logic [3:0]            mask,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic                  busy,
    output logic                  err
);

    localparam int IDXW = word_index_w(DEPTH_WORDS);

    dmem_state_t           r_state;
    logic [3:0]            r_cnt;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_ld_sel;
    logic                  r_we;
    logic [3:0]            r_mask;
    logic [ADDR_WIDTH-3:0] r_waddr;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_oor;
    logic [IDXW-1:0]       w_idx;
    logic                  w_acc;
    logic                  w_bank_en;
    logic [3:0]            w_bank_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_unused_lsb;

    assign w_unused_lsb = ^address[1:0];

    // Any set bit above the word-index field means the access misses the RAM.
    assign w_oor = |(r_waddr >> IDXW);
    assign w_idx = r_waddr[IDXW-1:0];

    // Gating on rst keeps a store whose ACCESS edge coincides with reset out of the RAM.
    assign w_acc     = (r_state == ACCESS) && rst && !w_oor;
    assign w_bank_en = w_acc && (!r_we || (r_mask != 4'b0000));
    assign w_bank_we = (w_acc && r_we) ? r_mask : 4'b0000;

    dmem_bank #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IDXW)
    ) u_bank (
        .clk   (clk),
        .en    (w_bank_en),
        .we    (w_bank_we),
        .addr  (w_idx),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_ld_sel <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (request) begin
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_err <= w_oor;
                    if (w_oor) begin
                        r_ld_sel <= 1'b0;
                    end else if (!r_we) begin
                        r_ld_sel <= 1'b1;
                    end
                    r_valid <= 1'b1;
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Request payload is captured only when a transaction is accepted.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && request) begin
            r_we    <= we_re;
            r_mask  <= mask;
            r_waddr <= address[ADDR_WIDTH-1:2];
            r_wdata <= store_data;
        end
    end

    assign load_data = r_ld_sel ? w_rdata : '0;
    assign valid     = r_valid;
    assign err       = r_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed steps plus random transactions
// compared against a word-array reference model.
module tb_dmem_ctrl;

    localparam int WS    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic        request0;
    logic        we_re;
    logic [3:0]  mask;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] load_data, load_data0;
    logic        valid, busy, err;
    logic        valid0, busy0, err0;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (WS)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .request    (request),
        .we_re      (we_re),
        .mask       (mask),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data),
        .valid      (valid),
        .busy       (busy),
        .err        (err)
    );

    dmem_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (32),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (0)
    ) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .request    (request0),
        .we_re      (we_re),
        .mask       (mask),
        .address    (address),
        .store_data (store_data),
        .load_data  (load_data0),
        .valid      (valid0),
        .busy       (busy0),
        .err        (err0)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ref_mem [int];
    logic [31:0] exp_ld   = 32'h0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction on the WS=2 instance; the model decides data, err and timing.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [3:0] m,
                       input logic [31:0] d, input bit scramble, input string tag);
        bit          oor;
        int          k;
        int          vc;
        logic [31:0] w;
        oor = ((a >> 2) >= DEPTH);
        k   = int'(a >> 2);
        if (oor) begin
            exp_ld = 32'h0;
        end else if (wr) begin
            w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (m[i]) w[8*i +: 8] = d[8*i +: 8];
            end
            ref_mem[k] = w;
        end else begin
            exp_ld = ref_mem[k];
        end
        request    = 1'b1;
        we_re      = wr;
        address    = a;
        mask       = m;
        store_data = d;
        vc = 0;
        for (int c = 1; c <= 16 && vc == 0; c++) begin
            tick();
            if (!scramble || c > WS) begin
                request = 1'b0;
            end else begin
                request    = 1'($urandom_range(0, 1));
                address    = $urandom;
                store_data = $urandom;
                we_re      = 1'($urandom_range(0, 1));
                mask       = 4'($urandom);
            end
            if (c == 1) chk({tag, ":busy_c1"}, 32'(busy), 32'd1);
            if (valid) vc = c;
        end
        chk({tag, ":latency"}, 32'(vc), 32'(WS + 2));
        chk({tag, ":err"}, 32'(err), 32'(oor));
        chk({tag, ":load_data"}, load_data, exp_ld);
        tick();
        chk({tag, ":idle_busy"}, 32'(busy), 32'd0);
        chk({tag, ":idle_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int          nv;
        int          v1;
        int          v2;
        logic [31:0] a;

        rst        = 1'b0;
        request    = 1'b1;
        request0   = 1'b0;
        we_re      = 1'b1;
        mask       = 4'hF;
        address    = 32'h0;
        store_data = 32'hFFFF_FFFF;
        tick();
        tick();
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_busy0", 32'(busy0), 32'd0);
        request = 1'b0;
        rst     = 1'b1;
        tick();
        chk("reset_no_txn", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            txn(1'b1, 32'(i * 4), 4'hF, (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_5A5A, 1'b0, "init");
        end

        txn(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, "st_word");
        txn(1'b0, 32'h10, 4'hF, 32'h0, 1'b0, "ld_word");
        chk("ld_word_value", load_data, 32'hDEAD_BEEF);
        txn(1'b1, 32'h10, 4'b0010, 32'h0000_AB00, 1'b0, "st_part");
        txn(1'b0, 32'h10, 4'b0000, 32'h0, 1'b0, "ld_part");
        chk("ld_part_value", load_data, 32'hDEAD_ABEF);

        txn(1'b1, 32'h1000, 4'hF, 32'h55AA_55AA, 1'b0, "st_oor");
        txn(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, "ld_zero");
        txn(1'b0, 32'h1000, 4'hF, 32'h0, 1'b0, "ld_oor");
        txn(1'b1, 32'h14, 4'b0000, 32'hFFFF_FFFF, 1'b0, "st_mask0");
        txn(1'b0, 32'h14, 4'hF, 32'h0, 1'b0, "ld_mask0");

        // Reset lands while the store is in WAIT.
        request    = 1'b1;
        we_re      = 1'b1;
        address    = 32'h20;
        mask       = 4'hF;
        store_data = 32'h1234_5678;
        tick();
        request = 1'b0;
        rst     = 1'b0;
        tick();
        rst = 1'b1;
        chk("rstmid_busy", 32'(busy), 32'd0);
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid) nv++;
        end
        chk("rstmid_no_valid", 32'(nv), 32'd0);
        exp_ld = 32'h0;
        chk("rstmid_load_data", load_data, exp_ld);
        txn(1'b0, 32'h20, 4'hF, 32'h0, 1'b0, "rstmid_ld");

        txn(1'b1, 32'h24, 4'hF, 32'h0BAD_F00D, 1'b1, "scr_st");
        txn(1'b0, 32'h24, 4'hF, 32'h0, 1'b0, "scr_ld");

        // Request held high: second load starts in the IDLE cycle after RESP.
        request = 1'b1;
        we_re   = 1'b0;
        address = 32'h10;
        mask    = 4'hF;
        nv = 0;
        v1 = 0;
        v2 = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 6) request = 1'b0;
            if (valid) begin
                nv++;
                if (v1 == 0) v1 = c;
                else v2 = c;
            end
        end
        exp_ld = ref_mem[4];
        chk("b2b_first", 32'(v1), 32'(WS + 2));
        chk("b2b_second", 32'(v2), 32'(2 * WS + 5));
        chk("b2b_count", 32'(nv), 32'd2);
        chk("b2b_load_data", load_data, exp_ld);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                a = $urandom;
                if ((a >> 2) < DEPTH) a = a | 32'h1000;
            end else begin
                a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            end
            txn(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom,
                ($urandom_range(0, 3) == 0), "rnd");
        end

        // Zero-wait-state instance with request held: valid every third cycle.
        request0   = 1'b1;
        we_re      = 1'b1;
        address    = 32'h4;
        mask       = 4'hF;
        store_data = 32'hCAFE_F00D;
        for (int c = 1; c <= 11; c++) begin
            tick();
            chk("ws0_valid", 32'(valid0), ((c % 3) == 2) ? 32'd1 : 32'd0);
        end
        request0 = 1'b0;
        tick();
        chk("ws0_idle", 32'(busy0), 32'd0);
        we_re    = 1'b0;
        request0 = 1'b1;
        tick();
        request0 = 1'b0;
        chk("ws0_ld_busy", 32'(busy0), 32'd1);
        tick();
        chk("ws0_ld_valid", 32'(valid0), 32'd1);
        chk("ws0_ld_data", load_data0, 32'hCAFE_F00D);
        chk("ws0_ld_err", 32'(err0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
